// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] BCD_ZERO     = 4'd0;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // True when a keypad code is a legal decimal digit.
  function automatic logic is_bcd(input logic [3:0] v);
    return (v <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD digit of the countdown: shiftable for keypad entry, clearable,
// and decrementing with borrow propagation toward the more significant digit.
module bcd_digit_down
  import bcd_countdown_timer_pkg::*;
(
  input  logic       clock,
  input  logic       clearn,
  input  logic       load,
  input  logic [3:0] shift_in,
  input  logic       clear,
  input  logic       borrow_in,
  input  logic [3:0] reload,
  output logic [3:0] value,
  output logic       borrow_out
);

  // Digit register: clear beats load, load beats decrement.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      value <= '0;
    end else if (clear) begin
      value <= BCD_ZERO;
    end else if (load) begin
      value <= shift_in;
    end else if (borrow_in) begin
      value <= (value == BCD_ZERO) ? reload : (value - 4'd1);
    end
  end

  // A borrow passes through only when this digit has to wrap.
  always_comb begin
    borrow_out = borrow_in & (value == BCD_ZERO);
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer: keypad digits shift in from the right, a start
// press counts down once per tick, door-open or stop pauses, done pulses
// for one cycle when the count reaches 00:00.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter logic [3:0] SEC_TENS_RELOAD = SEC_TENS_MAX,
  parameter logic [3:0] DIGIT_RELOAD    = BCD_MAX
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic [3:0] d,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       zero,
  output logic       done
);

  timer_state_t state, next_state;

  logic loadn_q, startn_q, stopn_q, pgt_q;
  logic load_ev, start_ev, stop_ev, tick_ev;
  logic shift_en, clear_en, dec_en, done_set, one_left;
  logic so_borrow, st_borrow, mo_borrow, mt_borrow;

  // Edge events from the previous-cycle copies of each input.
  always_comb begin
    load_ev  = ~loadn  & loadn_q;
    start_ev = ~startn & startn_q;
    stop_ev  = ~stopn  & stopn_q;
    tick_ev  = pgt_1hz & ~pgt_q;
  end

  // Status decoded straight from the digit registers.
  always_comb begin
    zero     = (min_tens == BCD_ZERO) && (min_ones == BCD_ZERO) &&
               (sec_tens == BCD_ZERO) && (sec_ones == BCD_ZERO);
    one_left = (min_tens == BCD_ZERO) && (min_ones == BCD_ZERO) &&
               (sec_tens == BCD_ZERO) && (sec_ones == 4'd1);
  end

  // Decrement only in COUNT when no higher-priority event is present and
  // there is something left to count.
  always_comb begin
    dec_en = (state == COUNT) & ~stop_ev & door_closed & tick_ev & ~zero;
  end

  // Next-state and digit control; priority stop > door open > start > tick.
  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    clear_en   = 1'b0;
    done_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (stop_ev) begin
          next_state = IDLE;
        end else if (start_ev && door_closed && !zero) begin
          next_state = COUNT;
        end else if (load_ev && is_bcd(d)) begin
          shift_en = 1'b1;
        end
      end
      COUNT: begin
        if (stop_ev || !door_closed) begin
          next_state = PAUSED;
        end else if (dec_en && (one_left || mt_borrow)) begin
          // A borrow out of min_tens would be an underflow; stop there too.
          next_state = DONE;
          done_set   = 1'b1;
        end
      end
      PAUSED: begin
        if (stop_ev) begin
          next_state = IDLE;
          clear_en   = 1'b1;
        end else if (start_ev && door_closed) begin
          next_state = COUNT;
        end
      end
      DONE: begin
        if (stop_ev) begin
          next_state = IDLE;
        end else if (load_ev && is_bcd(d)) begin
          next_state = IDLE;
          shift_en   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, registered status outputs and edge-detector history.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state    <= IDLE;
      running  <= 1'b0;
      done     <= 1'b0;
      loadn_q  <= 1'b1;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      pgt_q    <= 1'b0;
    end else begin
      state    <= next_state;
      running  <= (next_state == COUNT);
      done     <= done_set;
      loadn_q  <= loadn;
      startn_q <= startn;
      stopn_q  <= stopn;
      pgt_q    <= pgt_1hz;
    end
  end

  bcd_digit_down u_sec_ones (
    .clock      (clock),
    .clearn     (clearn),
    .load       (shift_en),
    .shift_in   (d),
    .clear      (clear_en),
    .borrow_in  (dec_en),
    .reload     (DIGIT_RELOAD),
    .value      (sec_ones),
    .borrow_out (so_borrow)
  );

  bcd_digit_down u_sec_tens (
    .clock      (clock),
    .clearn     (clearn),
    .load       (shift_en),
    .shift_in   (sec_ones),
    .clear      (clear_en),
    .borrow_in  (so_borrow),
    .reload     (SEC_TENS_RELOAD),
    .value      (sec_tens),
    .borrow_out (st_borrow)
  );

  bcd_digit_down u_min_ones (
    .clock      (clock),
    .clearn     (clearn),
    .load       (shift_en),
    .shift_in   (sec_tens),
    .clear      (clear_en),
    .borrow_in  (st_borrow),
    .reload     (DIGIT_RELOAD),
    .value      (min_ones),
    .borrow_out (mo_borrow)
  );

  bcd_digit_down u_min_tens (
    .clock      (clock),
    .clearn     (clearn),
    .load       (shift_en),
    .shift_in   (min_ones),
    .clear      (clear_en),
    .borrow_in  (mo_borrow),
    .reload     (DIGIT_RELOAD),
    .value      (min_tens),
    .borrow_out (mt_borrow)
  );

endmodule
